tetris_input_ctrl: RTL and testbench

Converts debounced keyboard levels into single-cycle action strobes for tetris_game (key_left/right/down/rotate/drop).
- Performs rising-edge detection and delayed auto-shift (DAS) repeat for left, right and down.
- Arbitrates so at most one action strobe is issued per cycle.
- Sits between the keyboard decoder and tetris_game; gated off while the game is not running.

---
 rtl/tetris_input_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_tetris_input_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tetris_input_ctrl.sv
// ---------------------------------------------------------------------------
// tetris_input_ctrl
//
// Turns debounced key levels into single-cycle action strobes for the game
// core.
//   * Rising-edge detection on every key.
//   * Delayed auto-shift (DAS) repeat on left, right and down.
//   * Priority arbitration so at most one strobe is issued per cycle.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   tick_input  one-cycle timebase strobe for the repeat timing
//   enable      game running; low suppresses all requests and flushes state
//   left_in, right_in, down_in, rotate_in, drop_in   debounced key levels
//   key_left, key_right, key_down, key_rotate, key_drop
//               registered one-cycle action strobes (at most one per cycle)
// ---------------------------------------------------------------------------
module tetris_input_ctrl #(
  parameter int DAS_DELAY = 16,
  parameter int DAS_RATE  = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_input,
  input  logic enable,
  input  logic left_in,
  input  logic right_in,
  input  logic down_in,
  input  logic rotate_in,
  input  logic drop_in,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate,
  output logic key_drop
);

  // Action bit order: 0 left, 1 right, 2 down, 3 rotate, 4 drop.
  // Only bits 0..2 have a repeat engine.
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  logic [4:0]       level_s;
  logic [4:0]       prev_r;
  logic [4:0]       rise_s;
  logic [4:0]       pending_r;
  logic [4:0]       grant_s;
  logic [4:0]       set_s;
  logic [4:0]       clear_s;
  logic [2:0]       fire_s;
  logic [2:0]       hold_s;
  logic             lr_both_s;
  rpt_state_t       rpt_state_r [3];
  logic [CNT_W-1:0] cnt_r [3];

  assign level_s   = {drop_in, rotate_in, down_in, right_in, left_in};
  assign rise_s    = level_s & ~prev_r;
  assign lr_both_s = left_in & right_in;

  // Repeat fire decision; left/right repeats freeze while both are held.
  always_comb begin
    fire_s = 3'b000;
    hold_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      hold_s[i] = (i < 2) ? lr_both_s : 1'b0;
      if (!enable || !level_s[i] || !tick_input || hold_s[i]) begin
        fire_s[i] = 1'b0;
      end else begin
        case (rpt_state_r[i])
          RPT_DELAY:  fire_s[i] = (cnt_r[i] == CNT_W'(DAS_DELAY - 1));
          RPT_REPEAT: fire_s[i] = (cnt_r[i] == CNT_W'(DAS_RATE - 1));
          default:    fire_s[i] = 1'b0;
        endcase
      end
    end
  end

  // Fixed-priority grant: drop > rotate > left > right > down.
  always_comb begin
    grant_s = 5'b00000;
    if (pending_r[4]) begin
      grant_s = 5'b10000;
    end else if (pending_r[3]) begin
      grant_s = 5'b01000;
    end else if (pending_r[0]) begin
      grant_s = 5'b00001;
    end else if (pending_r[1]) begin
      grant_s = 5'b00010;
    end else if (pending_r[2]) begin
      grant_s = 5'b00100;
    end else begin
      grant_s = 5'b00000;
    end
  end

  // New requests and the bits retired this cycle. A drop grant discards
  // every stale move; a request arriving on the same edge still survives.
  always_comb begin
    set_s   = (rise_s | {2'b00, fire_s}) & {5{enable}};
    clear_s = grant_s[4] ? 5'b11111 : grant_s;
  end

  // Edge history, pending bits and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r     <= 5'b00000;
      pending_r  <= 5'b00000;
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_down   <= 1'b0;
      key_rotate <= 1'b0;
      key_drop   <= 1'b0;
    end else begin
      // History tracks the keys even while disabled, so a key held across
      // enable rising must be released and pressed again.
      prev_r <= level_s;
      if (!enable) begin
        pending_r  <= 5'b00000;
        key_left   <= 1'b0;
        key_right  <= 1'b0;
        key_down   <= 1'b0;
        key_rotate <= 1'b0;
        key_drop   <= 1'b0;
      end else begin
        pending_r  <= (pending_r & ~clear_s) | set_s;
        key_left   <= grant_s[0];
        key_right  <= grant_s[1];
        key_down   <= grant_s[2];
        key_rotate <= grant_s[3];
        key_drop   <= grant_s[4];
      end
    end
  end

  // DAS repeat engines for left, right and down.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        rpt_state_r[i] <= RPT_IDLE;
        cnt_r[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!enable || !level_s[i]) begin
          rpt_state_r[i] <= RPT_IDLE;
          cnt_r[i]       <= '0;
        end else begin
          case (rpt_state_r[i])
            RPT_IDLE: begin
              // A tick coinciding with the press is deliberately not counted.
              if (rise_s[i]) begin
                rpt_state_r[i] <= RPT_DELAY;
                cnt_r[i]       <= '0;
              end else begin
                rpt_state_r[i] <= RPT_IDLE;
                cnt_r[i]       <= '0;
              end
            end
            RPT_DELAY: begin
              if (fire_s[i]) begin
                rpt_state_r[i] <= RPT_REPEAT;
                cnt_r[i]       <= '0;
              end else if (tick_input && !hold_s[i]) begin
                cnt_r[i] <= cnt_r[i] + CNT_W'(1);
              end else begin
                cnt_r[i] <= cnt_r[i];
              end
            end
            RPT_REPEAT: begin
              if (fire_s[i]) begin
                cnt_r[i] <= '0;
              end else if (tick_input && !hold_s[i]) begin
                cnt_r[i] <= cnt_r[i] + CNT_W'(1);
              end else begin
                cnt_r[i] <= cnt_r[i];
              end
            end
            default: begin
              rpt_state_r[i] <= RPT_IDLE;
              cnt_r[i]       <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
module tb_tetris_input_ctrl;

  logic clk = 1'b0;
  logic rst, tick_input, enable;
  logic left_in, right_in, down_in, rotate_in, drop_in;
  logic key_left, key_right, key_down, key_rotate, key_drop;

  int n_cmp = 0;
  int n_bad = 0;
  int c_l, c_r, c_d, c_rot, c_drop;

  tetris_input_ctrl #(.DAS_DELAY(16), .DAS_RATE(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .tick_input(tick_input), .enable(enable),
    .left_in(left_in), .right_in(right_in), .down_in(down_in),
    .rotate_in(rotate_in), .drop_in(drop_in),
    .key_left(key_left), .key_right(key_right), .key_down(key_down),
    .key_rotate(key_rotate), .key_drop(key_drop)
  );

  always #5 clk = ~clk;

  // Strobe counters and the one-hot invariant, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    c_l    = c_l + int'(key_left);
    c_r    = c_r + int'(key_right);
    c_d    = c_d + int'(key_down);
    c_rot  = c_rot + int'(key_rotate);
    c_drop = c_drop + int'(key_drop);
    n_cmp++;
    assert ((int'(key_left) + int'(key_right) + int'(key_down) + int'(key_rotate) + int'(key_drop)) <= 1)
    else begin
      n_bad++;
      $error("FAIL onehot obs=%b%b%b%b%b exp=at most one high", key_drop, key_rotate, key_left, key_right, key_down);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_input = 1'b1;
      cyc(1);
      tick_input = 1'b0;
      cyc(3);
    end
  endtask

  task automatic clr();
    c_l = 0; c_r = 0; c_d = 0; c_rot = 0; c_drop = 0;
  endtask

  function automatic int outs();
    return int'({key_drop, key_rotate, key_left, key_right, key_down});
  endfunction

  initial begin
    rst = 1'b1; tick_input = 1'b0; enable = 1'b0;
    left_in = 1'b0; right_in = 1'b0; down_in = 1'b0; rotate_in = 1'b0; drop_in = 1'b0;
    clr();
    cyc(3);
    check("reset_outs", outs(), 0);
    rst = 1'b0; enable = 1'b1;
    cyc(2);
    check("idle_outs", outs(), 0);

    // Single left tap: strobe exactly in cycle k+1..k+2.
    clr();
    left_in = 1'b1;
    cyc(1);
    left_in = 1'b0;
    check("tap_left_k", int'(key_left), 0);
    cyc(1);
    check("tap_left_k1", int'(key_left), 1);
    cyc(1);
    check("tap_left_k2", int'(key_left), 0);
    ticks(100);
    check("tap_left_total", c_l, 1);
    check("tap_other_total", c_r + c_d + c_rot + c_drop, 0);

    // Right held for 30 ticks: press + fires at ticks 16, 20, 24, 28.
    clr();
    right_in = 1'b1;
    cyc(1);
    ticks(15);
    check("das_before_delay", c_r, 1);
    ticks(1);
    check("das_first_repeat", c_r, 2);
    ticks(3);
    check("das_before_rate", c_r, 2);
    ticks(1);
    check("das_second_repeat", c_r, 3);
    ticks(10);
    check("das_30_ticks", c_r, 5);
    right_in = 1'b0;
    ticks(10);
    check("das_after_release", c_r, 5);

    // Rotate and left together: rotate first, left next cycle.
    clr();
    rotate_in = 1'b1; left_in = 1'b1;
    cyc(1);
    rotate_in = 1'b0; left_in = 1'b0;
    cyc(1);
    check("prio_rot_k1", int'(key_rotate), 1);
    check("prio_left_k1", int'(key_left), 0);
    cyc(1);
    check("prio_rot_k2", int'(key_rotate), 0);
    check("prio_left_k2", int'(key_left), 1);
    cyc(2);

    // Drop, rotate and down together: only drop survives.
    clr();
    drop_in = 1'b1; rotate_in = 1'b1; down_in = 1'b1;
    cyc(1);
    drop_in = 1'b0; rotate_in = 1'b0; down_in = 1'b0;
    cyc(1);
    check("drop_k1", int'(key_drop), 1);
    ticks(10);
    check("drop_total", c_drop, 1);
    check("drop_discard_rot", c_rot, 0);
    check("drop_discard_down", c_d, 0);

    // Left and right held together: one strobe each, no repeats.
    clr();
    left_in = 1'b1; right_in = 1'b1;
    cyc(1);
    ticks(40);
    check("lr_left", c_l, 1);
    check("lr_right", c_r, 1);
    left_in = 1'b0; right_in = 1'b0;
    cyc(2);

    // Down held across a disable window produces nothing after the press.
    clr();
    down_in = 1'b1;
    cyc(3);
    check("en_first_press", c_d, 1);
    enable = 1'b0;
    ticks(5);
    check("en_low_outs", outs(), 0);
    enable = 1'b1;
    ticks(20);
    check("en_held_no_strobe", c_d, 1);
    down_in = 1'b0;
    cyc(1);
    down_in = 1'b1;
    cyc(1);
    check("en_repress_k", int'(key_down), 0);
    cyc(1);
    check("en_repress_k1", int'(key_down), 1);
    down_in = 1'b0;
    cyc(2);
    check("en_total", c_d, 2);

    // Reset with left held: silent during reset, then a fresh press and DAS.
    clr();
    left_in = 1'b1;
    cyc(3);
    ticks(10);
    check("rst_pre_left", c_l, 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("rst_outs", outs(), 0);
    end
    rst = 1'b0;
    cyc(1);
    check("rst_left_k", int'(key_left), 0);
    cyc(1);
    check("rst_left_k1", int'(key_left), 1);
    ticks(15);
    check("rst_das_restart", c_l, 2);
    ticks(1);
    check("rst_das_fire", c_l, 3);
    left_in = 1'b0;
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
